// File: rtl/segre_if_fetch_queue_pkg.sv
// Shared fetch-queue types: FSM states, queue entry layout, NOP and control-flow opcodes.
// Imported by the fetch queue top and its interface users.
package segre_if_fetch_queue_pkg;

    typedef enum logic [1:0] {
        FQ_FETCH = 2'd0,
        FQ_WAIT  = 2'd1,
        FQ_DRAIN = 2'd2,
        FQ_HOLD  = 2'd3
    } fq_state_t;

    localparam int unsigned FQ_PC_W = 32;

    typedef struct packed {
        logic [31:0]        instr;
        logic [FQ_PC_W-1:0] pc;
    } fq_entry_t;

    localparam logic [31:0] INSTR_NOP     = 32'h0000_0013;
    localparam logic [6:0]  OPCODE_BRANCH = 7'h63;
    localparam logic [6:0]  OPCODE_JAL    = 7'h6f;
    localparam logic [6:0]  OPCODE_JALR   = 7'h67;

    function automatic logic is_ctrl_flow(input logic [6:0] opcode);
        return (opcode == OPCODE_BRANCH) || (opcode == OPCODE_JAL) || (opcode == OPCODE_JALR);
    endfunction

endpackage

// File: rtl/segre_if_fetch_queue_if.sv
// I-cache request/response, redirect and ID-side handshake bundle of the fetch queue.
// master = fetch queue, slave = surrounding core / memory side.
interface segre_if_fetch_queue_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
);
    logic                   ic_req_o;
    logic [ADDR_W-1:0]      ic_addr_o;
    logic                   ic_gnt_i;
    logic                   ic_rvalid_i;
    logic [31:0]            ic_rdata_i;
    logic                   redirect_i;
    logic [ADDR_W-1:0]      redirect_pc_i;
    logic                   branch_completed_i;
    logic                   id_valid_o;
    logic                   id_ready_i;
    logic [31:0]            instr_o;
    logic [ADDR_W-1:0]      pc_o;
    logic [$clog2(DEPTH):0] fq_count_o;

    modport master (
        output ic_req_o, ic_addr_o, id_valid_o, instr_o, pc_o, fq_count_o,
        input  ic_gnt_i, ic_rvalid_i, ic_rdata_i, redirect_i, redirect_pc_i,
               branch_completed_i, id_ready_i
    );

    modport slave (
        input  ic_req_o, ic_addr_o, id_valid_o, instr_o, pc_o, fq_count_o,
        output ic_gnt_i, ic_rvalid_i, ic_rdata_i, redirect_i, redirect_pc_i,
               branch_completed_i, id_ready_i
    );
endinterface

// File: rtl/segre_fetch_fifo.sv
// Circular FIFO holding fetched {instr, pc}; head visible combinationally, 1-cycle push-to-head.
// Push when full and pop when empty are ignored; flush empties it in one cycle.
module segre_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != FULL_CNT);
    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/segre_if_fetch_queue.sv
// Fetch stage: one-outstanding I-cache requester feeding a DEPTH-entry queue; head reaches ID with 0-cycle latency.
// Full queue or HOLD stalls requests; SEGRE_IF_BRANCH_HOLD_EN makes fetch stop after a control-flow instruction.
module segre_if_fetch_queue
    import segre_if_fetch_queue_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                    clk_i,
    input logic                    rst_i,
    segre_if_fetch_queue_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fq_state_t         state;
    fq_state_t         state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] issued_pc;
    logic [CW-1:0]     count;
    logic [31+ADDR_W:0] push_dat;
    logic [31+ADDR_W:0] head_dat;
    fq_entry_t         enq_ent;
    fq_entry_t         head_ent;
    logic              req;
    logic              grant;
    logic              enq;
    logic              deq;
    logic              valid;

    assign req   = !rst_i && (state == FQ_FETCH) && (count < FULL_CNT);
    assign grant = req && bus.ic_gnt_i;
    assign valid = (count != '0);
    // A redirect wins over any same-cycle enqueue or dequeue.
    assign enq   = (state == FQ_WAIT) && bus.ic_rvalid_i && !bus.redirect_i;
    assign deq   = valid && bus.id_ready_i && !bus.redirect_i;

    always_comb begin
        enq_ent       = '0;
        enq_ent.instr = bus.ic_rdata_i;
        enq_ent.pc    = FQ_PC_W'(issued_pc);
        push_dat      = {enq_ent.instr, enq_ent.pc[ADDR_W-1:0]};
        head_ent       = '0;
        head_ent.instr = head_dat[ADDR_W +: 32];
        head_ent.pc    = FQ_PC_W'(head_dat[ADDR_W-1:0]);
    end

    segre_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32 + ADDR_W)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .flush    (bus.redirect_i),
        .push     (enq),
        .push_dat (push_dat),
        .pop      (deq),
        .head_dat (head_dat),
        .count    (count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= FQ_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.redirect_i && (state != FQ_DRAIN)) begin
            // An in-flight (or just granted) request must have its response dropped.
            if (((state == FQ_WAIT) && !bus.ic_rvalid_i) || grant) state_nxt = FQ_DRAIN;
            else                                                  state_nxt = FQ_FETCH;
        end else begin
            case (state)
                FQ_FETCH: if (grant) state_nxt = FQ_WAIT;
                FQ_WAIT: begin
                    if (bus.ic_rvalid_i) begin
`ifdef SEGRE_IF_BRANCH_HOLD_EN
                        state_nxt = is_ctrl_flow(bus.ic_rdata_i[6:0]) ? FQ_HOLD : FQ_FETCH;
`else
                        state_nxt = FQ_FETCH;
`endif
                    end
                end
                FQ_DRAIN: if (bus.ic_rvalid_i) state_nxt = FQ_FETCH;
                FQ_HOLD:  if (bus.branch_completed_i) state_nxt = FQ_FETCH;
                default:  state_nxt = FQ_FETCH;
            endcase
        end
    end

    always_comb begin
        bus.ic_req_o   = req;
        bus.ic_addr_o  = fetch_pc;
        bus.id_valid_o = valid;
        bus.instr_o    = valid ? head_ent.instr : INSTR_NOP;
        bus.pc_o       = valid ? head_ent.pc[ADDR_W-1:0] : '0;
        bus.fq_count_o = count;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= '0;
        end else begin
            if (bus.redirect_i) fetch_pc <= bus.redirect_pc_i;
            else if (grant)     fetch_pc <= fetch_pc + ADDR_W'(4);
            if (grant) issued_pc <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_segre_if_fetch_queue.sv
// Bench for segre_if_fetch_queue: cycle table for fill/full behaviour, directed redirect/reset/branch
// sequences, and a randomized run, all checked by a fetch-PC model plus an in-order scoreboard.
module tb_segre_if_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;

    segre_if_fetch_queue_if #(.ADDR_W(32), .DEPTH(4)) bus ();

    segre_if_fetch_queue #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_grant  = 0;
    int n_pop    = 0;
    int lat      = 1;

    logic        s_req, s_valid, s_gnt;
    logic [31:0] s_addr, s_pc, s_instr, s_count;

    logic [63:0] sb[$];
    logic [31:0] exp_fpc = 32'h0;
    logic [31:0] rsp_addr, rsp_dat_addr, dlv_addr, hold_addr;
    int          rsp_cnt = 0;
    bit          rsp_busy = 0, rsp_keep = 0, dlv_keep = 0, hold_pending = 0;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        req;
        logic        vld;
        int          cnt;
        logic [31:0] pc;
        logic [31:0] addr;
    } vec_t;
    vec_t vt[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_for(input logic [31:0] a);
        if (a == 32'h10) return 32'h0000_0063;
        return {a[19:0], 5'd1, 7'h13};
    endfunction

    // One clock cycle: sample at negedge, update model, then drive the cache response after posedge.
    task automatic tick();
        logic granted;
        logic [63:0] e;
        @(negedge clk);
        s_req   = bus.ic_req_o;
        s_addr  = bus.ic_addr_o;
        s_valid = bus.id_valid_o;
        s_count = 32'(bus.fq_count_o);
        s_pc    = bus.pc_o;
        s_instr = bus.instr_o;
        granted = s_req && bus.ic_gnt_i;
        s_gnt   = granted;
        if (hold_pending && !rst) begin
            check("req_held", 32'(s_req), 32'h1);
            check("addr_held", s_addr, hold_addr);
        end
        hold_pending = s_req && !granted && !rst && !bus.redirect_i;
        hold_addr    = s_addr;
        if (granted) begin
            check("ic_addr", s_addr, exp_fpc);
            n_grant++;
            rsp_busy     = 1;
            rsp_cnt      = lat;
            rsp_addr     = exp_fpc;
            rsp_dat_addr = s_addr;
            rsp_keep     = 1;
            exp_fpc      = exp_fpc + 32'h4;
        end
        if (rst) begin
            exp_fpc = 32'h0;
            sb.delete();
            rsp_keep = 0;
        end else if (bus.redirect_i) begin
            exp_fpc = bus.redirect_pc_i;
            sb.delete();
            rsp_keep = 0;
        end else begin
            if (bus.ic_rvalid_i && dlv_keep) sb.push_back({dlv_addr, instr_for(dlv_addr)});
            if (s_valid && bus.id_ready_i) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'h1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("deq_pc", s_pc, e[63:32]);
                    check("deq_instr", s_instr, e[31:0]);
                    n_pop++;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.ic_rvalid_i = 1'b0;
        if (rsp_busy) begin
            rsp_cnt--;
            if (rsp_cnt <= 0) begin
                rsp_busy        = 0;
                bus.ic_rvalid_i = 1'b1;
                bus.ic_rdata_i  = instr_for(rsp_dat_addr);
                dlv_keep        = rsp_keep;
                dlv_addr        = rsp_addr;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_i = 1'b0;
        bus.branch_completed_i = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        n_grant = 0;
        n_pop   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1;
        bus.ic_gnt_i = 1'b1;
        bus.ic_rvalid_i = 1'b0;
        bus.ic_rdata_i = 32'h0;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.branch_completed_i = 1'b0;
        bus.id_ready_i = 1'b0;

        //       rst rdy req vld cnt pc     addr
        vt[0]  = '{1, 0, 0, 0, 0, 32'h0, 32'h0};
        vt[1]  = '{0, 0, 1, 0, 0, 32'h0, 32'h0};
        vt[2]  = '{0, 0, 0, 0, 0, 32'h0, 32'h0};
        vt[3]  = '{0, 0, 1, 1, 1, 32'h0, 32'h4};
        vt[4]  = '{0, 0, 0, 1, 1, 32'h0, 32'h0};
        vt[5]  = '{0, 0, 1, 1, 2, 32'h0, 32'h8};
        vt[6]  = '{0, 0, 0, 1, 2, 32'h0, 32'h0};
        vt[7]  = '{0, 0, 1, 1, 3, 32'h0, 32'hc};
        vt[8]  = '{0, 0, 0, 1, 3, 32'h0, 32'h0};
        vt[9]  = '{0, 0, 0, 1, 4, 32'h0, 32'h0};
        vt[10] = '{0, 0, 0, 1, 4, 32'h0, 32'h0};
        vt[11] = '{0, 1, 0, 1, 4, 32'h0, 32'h0};
        vt[12] = '{0, 0, 1, 1, 3, 32'h4, 32'h10};
        vt[13] = '{0, 0, 0, 1, 3, 32'h4, 32'h0};
        vt[14] = '{0, 0, 0, 1, 4, 32'h4, 32'h0};

        // Fill to full with ID stalled, then one dequeue releases exactly one request.
        lat = 1;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            rst = vt[i].rst;
            bus.id_ready_i = vt[i].rdy;
            tick();
            check($sformatf("row%0d_req", i), 32'(s_req), 32'(vt[i].req));
            check($sformatf("row%0d_valid", i), 32'(s_valid), 32'(vt[i].vld));
            check($sformatf("row%0d_count", i), s_count, 32'(vt[i].cnt));
            check($sformatf("row%0d_pc", i), s_pc, vt[i].pc);
            check($sformatf("row%0d_instr", i), s_instr, vt[i].vld ? instr_for(vt[i].pc) : NOP);
            if (vt[i].req) check($sformatf("row%0d_addr", i), s_addr, vt[i].addr);
            if (i == 10) check("grants_when_full", 32'(n_grant), 32'd4);
        end
        check("grants_after_deq", 32'(n_grant), 32'd5);

        // Streaming with ID always ready: in-order delivery, one instruction every two cycles.
        do_reset();
        bus.id_ready_i = 1'b1;
        repeat (30) tick();
        check("stream_pops", 32'(n_pop), 32'd14);

        // Redirect while the request to 0x8 is outstanding.
        lat = 3;
        do_reset();
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (s_gnt && s_addr == 32'h8) found = 1;
        end
        check("redir_grant8_seen", 32'(found), 32'h1);
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h100;
        tick();
        bus.redirect_i = 1'b0;
        tick();
        check("redir_count_after", s_count, 32'h0);
        check("redir_req_drain", 32'(s_req), 32'h0);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (s_valid) found = 1;
        end
        check("redir_valid_seen", 32'(found), 32'h1);
        check("redir_first_pc", s_pc, 32'h100);

        // Branch opcode enqueued at 0x10.
        lat = 1;
        do_reset();
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (s_gnt && s_addr == 32'h10) found = 1;
        end
        check("br_grant10_seen", 32'(found), 32'h1);
        tick();
        tick();
`ifdef SEGRE_IF_BRANCH_HOLD_EN
        check("br_hold_req", 32'(s_req), 32'h0);
        tick();
        check("br_hold_req2", 32'(s_req), 32'h0);
        bus.branch_completed_i = 1'b1;
        tick();
        bus.branch_completed_i = 1'b0;
        tick();
`endif
        check("br_next_req", 32'(s_req), 32'h1);
        check("br_next_addr", s_addr, 32'h14);

        // Reset while waiting; the late response must be ignored.
        lat = 2;
        do_reset();
        tick();
        check("rst_first_grant", 32'(s_gnt), 32'h1);
        rst = 1'b1;
        tick();
        check("rst_req_low", 32'(s_req), 32'h0);
        rst = 1'b0;
        tick();
        check("rst_refetch_req", 32'(s_req), 32'h1);
        check("rst_refetch_addr", s_addr, 32'h0);
        tick();
        check("rst_count_zero", s_count, 32'h0);
        check("rst_valid_zero", 32'(s_valid), 32'h0);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (s_valid) found = 1;
        end
        check("rst_valid_seen", 32'(found), 32'h1);
        check("rst_first_pc", s_pc, 32'h0);

        // Randomized grants, ID backpressure, latencies and redirects.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bus.ic_gnt_i = 1'($urandom_range(0, 1));
            bus.id_ready_i = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(1, 3);
            bus.redirect_i = ($urandom_range(0, 15) == 0);
            bus.redirect_pc_i = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            tick();
            bus.redirect_i = 1'b0;
        end
        check("rand_pops_nonzero", 32'(n_pop != 0), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/segre_if_fetch_queue.md
SEGRE_IF_FETCH_QUEUE -- requirements
Module: segre_if_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, fetch address width.
REQ-002 SHALL have parameter DEPTH, default 4, fetch-queue entries (power of two, 2..16).
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-004 SHALL have port clk_i input 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i input 1, reset, synchronous, active-high.
REQ-006 SHALL have port ic_req_o output 1, I-cache request valid.
REQ-007 SHALL have port ic_addr_o output ADDR_W, request address.
REQ-008 SHALL have port ic_gnt_i input 1, request accepted this cycle.
REQ-009 SHALL have port ic_rvalid_i input 1, response valid (>=1 cycle after grant).
REQ-010 SHALL have port ic_rdata_i input 32, response instruction word.
REQ-011 SHALL have port redirect_i input 1, taken branch/jump from WB.
REQ-012 SHALL have port redirect_pc_i input ADDR_W, redirect target.
REQ-013 SHALL have port branch_completed_i input 1, branch resolved in WB.
REQ-014 SHALL have port id_valid_o output 1, instruction available to ID.
REQ-015 SHALL have port id_ready_i input 1, ID accepts this cycle.
REQ-016 SHALL have port instr_o output 32, head instruction; NOP (0x00000013) when empty.
REQ-017 SHALL have port pc_o output ADDR_W, PC of head instruction.
REQ-018 SHALL have port fq_count_o output $clog2(DEPTH)+1, occupied entries.

Function
REQ-019 SHALL keep fetch PC; advance by 4 on each grant.
REQ-020 SHALL allow at most one outstanding request; assert ic_req_o only in FETCH and when fq_count + outstanding < DEPTH.
REQ-021 SHALL hold ic_req_o and ic_addr_o stable until ic_gnt_i.
REQ-022 SHALL enqueue {ic_rdata_i, issued PC} on ic_rvalid_i unless discarding; queue is circular, pointers wrap modulo DEPTH.
REQ-023 SHALL dequeue head when id_valid_o && id_ready_i; same-cycle enqueue and dequeue leave fq_count_o unchanged.
REQ-024 SHALL drive id_valid_o = (fq_count_o != 0), combinational from registered state, zero-cycle head-to-ID latency.
REQ-025 SHALL implement FSM states FETCH, WAIT, DRAIN, HOLD.
REQ-026 FETCH -> WAIT on grant; WAIT -> FETCH on ic_rvalid_i.
REQ-027 On redirect_i: flush queue (count 0, pointers reset), load fetch PC = redirect_pc_i; go WAIT->DRAIN if a request is outstanding, else FETCH; redirect beats any same-cycle enqueue, dequeue or grant (granted request then counts as outstanding and is drained).
REQ-028 DRAIN SHALL discard the next ic_rvalid_i, then go FETCH; a further redirect in DRAIN only updates fetch PC.
REQ-029 Full queue SHALL suppress requests; empty queue SHALL give id_valid_o=0 and instr_o=NOP.

Reset
REQ-030 On rst_i: state FETCH, fetch PC = RESET_PC, queue empty, no outstanding request; ic_req_o=0, id_valid_o=0, instr_o=NOP, pc_o=0, fq_count_o=0 in the following cycle; reset mid-transaction SHALL drop any pending response.
REQ-031 ic_req_o SHALL be 0 while rst_i is high.

Configuration
REQ-032 Macro SEGRE_IF_BRANCH_HOLD_EN defined: enqueuing an opcode OPCODE_BRANCH/OPCODE_JAL/OPCODE_JALR moves FSM to HOLD (no requests) until branch_completed_i or redirect_i, then FETCH.
REQ-033 Macro undefined: HOLD unreachable; fetch continues sequentially, wrong-path entries removed only by redirect flush.

Structure
REQ-034 Shared package SHALL hold fetch-queue FSM enum, queue entry struct {instr, pc}, NOP and opcode constants.
REQ-035 Queue storage and pointers SHALL be sub-module segre_fetch_fifo (parameter DEPTH, width 32+ADDR_W).

Verification
REQ-036 Reset, gnt=1, rvalid 1 cycle later, id_ready=1 -> pc_o sequence 0x0,0x4,0x8 in order, no gaps after fill.
REQ-037 DEPTH=4, id_ready=0 -> exactly 4 grants, fq_count_o=4, ic_req_o=0 thereafter; one dequeue -> one new request.
REQ-038 Redirect to 0x100 while request to 0x8 outstanding -> 0x8 response discarded, next enqueued pc_o=0x100, fq_count_o=0 cycle after redirect.
REQ-039 With SEGRE_IF_BRANCH_HOLD_EN, enqueue 0x00000063 at 0x10 -> no request until branch_completed_i; without macro, request for 0x14 issues next cycle.
REQ-040 rst_i asserted while WAIT, rvalid on next cycle -> response ignored, first post-reset fetch at RESET_PC.
